// File: rtl/cmplx_mult_seq.sv
// Sequencer for one signed complex product over a single shared unsigned DWIDTH x DWIDTH multiplier.
// Optional feature macro CMPLX_MULT_SAT_EN: clamp outputs to 2*DWIDTH bits and add the out_sat port.

module cmplx_mult_seq #(
  parameter int DWIDTH = 8,
`ifdef CMPLX_MULT_SAT_EN
  localparam int OW = 2*DWIDTH
`else
  localparam int OW = 2*DWIDTH + 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic signed [DWIDTH-1:0] in_a_re,
  input  logic signed [DWIDTH-1:0] in_a_im,
  input  logic signed [DWIDTH-1:0] in_b_re,
  input  logic signed [DWIDTH-1:0] in_b_im,
  output logic [DWIDTH-1:0]        mul_op1,
  output logic [DWIDTH-1:0]        mul_op2,
  input  logic [2*DWIDTH-1:0]      mul_result,
  output logic                     out_vld,
  input  logic                     out_rdy,
`ifdef CMPLX_MULT_SAT_EN
  output logic                     out_sat,
`endif
  output logic signed [OW-1:0]     out_re,
  output logic signed [OW-1:0]     out_im
);

  localparam int AW = 2*DWIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_AC, S_MUL_BD, S_MUL_AD, S_MUL_BC, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic signed [DWIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
  logic signed [AW-1:0]     r_re_acc, r_im_acc;
  logic signed [OW-1:0]     r_out_re, r_out_im;

  logic signed [DWIDTH-1:0] w_x, w_y;
  logic                     w_neg;
  logic signed [AW-1:0]     w_prod, w_p, w_im_sum;
  logic signed [OW-1:0]     w_re_fin, w_im_fin;

  function automatic logic [DWIDTH-1:0] f_mag(input logic signed [DWIDTH-1:0] x);
    return x[DWIDTH-1] ? -x : x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_vld) w_next = S_MUL_AC;
      S_MUL_AC: w_next = S_MUL_BD;
      S_MUL_BD: w_next = S_MUL_AD;
      S_MUL_AD: w_next = S_MUL_BC;
      S_MUL_BC: w_next = S_DONE;
      S_DONE:   if (out_rdy) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand pair steering; zero outside the multiply states keeps the multiplier quiet.
  always_comb begin
    in_rdy  = (r_state == S_IDLE);
    out_vld = (r_state == S_DONE);
    w_x     = '0;
    w_y     = '0;
    case (r_state)
      S_MUL_AC: begin w_x = r_a_re; w_y = r_b_re; end
      S_MUL_BD: begin w_x = r_a_im; w_y = r_b_im; end
      S_MUL_AD: begin w_x = r_a_re; w_y = r_b_im; end
      S_MUL_BC: begin w_x = r_a_im; w_y = r_b_re; end
      default:  begin w_x = '0;     w_y = '0;     end
    endcase
  end

  assign mul_op1  = f_mag(w_x);
  assign mul_op2  = f_mag(w_y);
  assign w_neg    = w_x[DWIDTH-1] ^ w_y[DWIDTH-1];
  assign w_prod   = signed'({1'b0, mul_result});
  assign w_p      = w_neg ? -w_prod : w_prod;
  assign w_im_sum = r_im_acc + w_p;

`ifdef CMPLX_MULT_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {2'b00, {(2*DWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {2'b11, {(2*DWIDTH-1){1'b0}}};

  logic w_re_sat, w_im_sat, r_out_sat;

  function automatic logic [OW:0] f_sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[OW-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  assign {w_re_sat, w_re_fin} = f_sat(r_re_acc);
  assign {w_im_sat, w_im_fin} = f_sat(w_im_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_out_sat <= 1'b0;
    else if (r_state == S_MUL_BC) r_out_sat <= w_re_sat | w_im_sat;
  end

  assign out_sat = r_out_sat;
`else
  assign w_re_fin = r_re_acc;
  assign w_im_fin = w_im_sum;
`endif

  // The real sum is complete after MUL_BD, so both results are latched on the MUL_BC edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_re   <= '0;
      r_a_im   <= '0;
      r_b_re   <= '0;
      r_b_im   <= '0;
      r_re_acc <= '0;
      r_im_acc <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_vld) begin
          r_a_re <= in_a_re;
          r_a_im <= in_a_im;
          r_b_re <= in_b_re;
          r_b_im <= in_b_im;
        end
        S_MUL_AC: r_re_acc <= w_p;
        S_MUL_BD: r_re_acc <= r_re_acc - w_p;
        S_MUL_AD: r_im_acc <= w_p;
        S_MUL_BC: begin
          r_im_acc <= w_im_sum;
          r_out_re <= w_re_fin;
          r_out_im <= w_im_fin;
        end
        default: ;
      endcase
    end
  end

  assign out_re = r_out_re;
  assign out_im = r_out_im;

  property p_hold_under_bp;
    @(posedge clk) disable iff (rst)
      (out_vld && !out_rdy) |=> (out_vld && $stable(out_re) && $stable(out_im));
  endproperty
  a_hold_under_bp: assert property (p_hold_under_bp);

endmodule
